axi2per_w_buffer: RTL and testbench
===================================

Name: axi2per_w_buffer

Overview:
- Elastic buffer on the AXI4 write-data (W) channel of the axi2per bridge, in the master-to-bridge direction; it complements the read-data buffer in the same bridge.
- Holds up to BUFFER_DEPTH W beats in its own circular FIFO. This decouples the AXI master from the peripheral-side write FSM.
- Exports occupancy and a count of complete bursts held, so the FSM can start a peripheral write only once the full burst is present.

Parameters:
- DATA_WIDTH, 64, W data width in bits.
- USER_WIDTH, 6, W user sideband width.
- BUFFER_DEPTH, 4, FIFO entries; power of two, >= 2.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width; do not override.
- CNT_WIDTH, $clog2(BUFFER_DEPTH)+1, counter width; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- slave_valid_i  in  1  W beat valid from AXI master.
- slave_data_i  in  DATA_WIDTH  write data.
- slave_strb_i  in  STRB_WIDTH  byte strobes.
- slave_user_i  in  USER_WIDTH  user sideband.
- slave_last_i  in  1  last beat of burst.
- slave_ready_o  out  1  buffer can accept a beat.
- master_valid_o  out  1  head entry valid toward bridge FSM.
- master_data_o  out  DATA_WIDTH  head data.
- master_strb_o  out  STRB_WIDTH  head strobes.
- master_user_o  out  USER_WIDTH  head user.
- master_last_o  out  1  head last flag.
- master_ready_i  in  1  bridge consumes head.
- count_o  out  CNT_WIDTH  entries held.
- bursts_o  out  CNT_WIDTH  entries held with last=1, i.e. complete bursts.

Behaviour:
- Storage: BUFFER_DEPTH entries of {user, strb, data, last}, with write pointer, read pointer and an occupancy counter. Pointers wrap modulo BUFFER_DEPTH.
- Reset (rst_ni=0 at a clk_i edge):
  - Pointers, count and bursts go to 0; storage is cleared to 0.
  - While rst_ni=0: slave_ready_o=0, master_valid_o=0, and all master_* payload outputs are 0.
  - A reset asserted mid-burst discards all held beats; there is no partial drain.
- Flags, both combinational from registered state only, with no input-to-output path:
  - full = (count == BUFFER_DEPTH)
  - empty = (count == 0)
- slave_ready_o = !full && rst_ni. push = slave_valid_i && slave_ready_o.
- master_valid_o = !empty. pop = master_valid_o && master_ready_i.
- Payload outputs always reflect the entry at the read pointer, stable while master_valid_o=1 and not popped.
- No fall-through: a beat pushed in cycle N is visible at master_* in cycle N+1 at the earliest. Minimum latency is 1 cycle and full throughput is 1 beat/cycle.
- Simultaneous push and pop:
  - When not full, both occur and count is unchanged.
  - When full, slave_ready_o=0, so only the pop occurs; the freed slot is accepted the next cycle.
  - When empty, only the push occurs because master_valid_o=0.
- bursts_o:
  - +1 on push with slave_last_i=1.
  - -1 on pop with master_last_o=1.
  - Both in the same cycle leave it unchanged.
  - Always satisfies bursts_o <= count_o.
- AXI stability is the master's responsibility. The buffer samples inputs only on push.
- No overflow or underflow is possible by construction. An SVA asserts count never exceeds BUFFER_DEPTH.

Test Plan:
1. Reset, then idle: slave_ready_o=1, master_valid_o=0, count_o=0, bursts_o=0. Hold rst_ni=0: slave_ready_o=0.
2. Push 4 beats, data 0x11..0x44, last on the 4th, master_ready_i=0:
   - slave_ready_o drops after the 4th push; count_o=4, bursts_o=1.
   - A 5th beat is stalled, not accepted.
3. From full, assert master_ready_i and slave_valid_i together:
   - Pops return 0x11, 0x22, ... in order with strb/user intact.
   - The stalled 5th beat is accepted the cycle after the first pop. Sustained 1 beat/cycle follows, with count_o steady at 3 or 4.
4. Back-to-back single-beat bursts, all last=1, with master_ready_i=1:
   - Each beat appears 1 cycle after push.
   - bursts_o stays at 1 during steady flow and returns to 0 after the final pop.
5. Wrap-around: 10 pushes/pops with random stalls at depth 4. Output order and payload match a scoreboard, with no duplication or loss.
6. Reset mid-burst with 3 beats held: the next cycle shows count_o=0, bursts_o=0, master_valid_o=0. A new beat pushed after release emerges first.

Source files
------------

// File: rtl/axi2per_w_buffer.sv
// AXI4 W-channel elastic buffer for the axi2per bridge: circular FIFO with occupancy
// and complete-burst counters so the write FSM can wait for a whole burst.
module axi2per_w_buffer #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned USER_WIDTH   = 6,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [STRB_WIDTH-1:0] slave_strb_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,

    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [STRB_WIDTH-1:0] master_strb_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,

    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [CNT_WIDTH-1:0]  bursts_o
);

    localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
    localparam logic [CNT_WIDTH-1:0] Depth = CNT_WIDTH'(BUFFER_DEPTH);

    typedef struct packed {
        logic [USER_WIDTH-1:0] user;
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    entry_t               mem_q [BUFFER_DEPTH];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] bursts_q, bursts_d;

    entry_t head;
    entry_t entry_in;
    logic   full, empty, push, pop;
    logic   push_last, pop_last;

    assign head     = mem_q[rptr_q];
    assign entry_in = '{user: slave_user_i, strb: slave_strb_i,
                        data: slave_data_i, last: slave_last_i};

    always_comb begin
        full           = (count_q == Depth);
        empty          = (count_q == '0);
        slave_ready_o  = !full && rst_ni;
        master_valid_o = !empty && rst_ni;
        push           = slave_valid_i && slave_ready_o;
        pop            = master_valid_o && master_ready_i;
        push_last      = push && slave_last_i;
        pop_last       = pop && head.last;

        // Gating on rst_ni keeps the payload quiet before the first reset edge clears storage.
        master_data_o  = rst_ni ? head.data : '0;
        master_strb_o  = rst_ni ? head.strb : '0;
        master_user_o  = rst_ni ? head.user : '0;
        master_last_o  = rst_ni ? head.last : 1'b0;
        count_o        = count_q;
        bursts_o       = bursts_q;
    end

    always_comb begin
        wptr_d   = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d   = pop  ? rptr_q + PtrW'(1) : rptr_q;
        count_d  = count_q;
        bursts_d = bursts_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        if (push_last && !pop_last) begin
            bursts_d = bursts_q + CNT_WIDTH'(1);
        end else if (!push_last && pop_last) begin
            bursts_d = bursts_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            bursts_q <= '0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            bursts_q <= bursts_d;
            if (push) begin
                mem_q[wptr_q] <= entry_in;
            end
        end
    end

    count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= Depth);
    bursts_le_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bursts_q <= count_q);

endmodule

// File: tb/tb_axi2per_w_buffer.sv
// Scenario bench for axi2per_w_buffer: a negedge monitor scores every popped beat against
// a queue of accepted beats; each task checks its own scenario-specific values.
module tb_axi2per_w_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        slave_valid_i;
    logic [63:0] slave_data_i;
    logic [7:0]  slave_strb_i;
    logic [5:0]  slave_user_i;
    logic        slave_last_i;
    logic        slave_ready_o;
    logic        master_valid_o;
    logic [63:0] master_data_o;
    logic [7:0]  master_strb_o;
    logic [5:0]  master_user_o;
    logic        master_last_o;
    logic        master_ready_i;
    logic [2:0]  count_o;
    logic [2:0]  bursts_o;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [5:0]  user;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    npops  = 0;

    axi2per_w_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .slave_valid_i  (slave_valid_i),
        .slave_data_i   (slave_data_i),
        .slave_strb_i   (slave_strb_i),
        .slave_user_i   (slave_user_i),
        .slave_last_i   (slave_last_i),
        .slave_ready_o  (slave_ready_o),
        .master_valid_o (master_valid_o),
        .master_data_o  (master_data_o),
        .master_strb_o  (master_strb_o),
        .master_user_o  (master_user_o),
        .master_last_o  (master_last_o),
        .master_ready_i (master_ready_i),
        .count_o        (count_o),
        .bursts_o       (bursts_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [7:0] strb_of(input logic [63:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [5:0] user_of(input logic [63:0] d);
        return d[13:8] ^ 6'h15;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        slave_valid_i = v;
        slave_data_i  = d;
        slave_strb_i  = strb_of(d);
        slave_user_i  = user_of(d);
        slave_last_i  = l;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Mid-cycle monitor: pops are scored first, then accepted beats are queued.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (master_valid_o && master_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got data=%h exp none", master_data_o);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    npops++;
                    if (master_data_o !== e.data || master_strb_o !== e.strb ||
                        master_user_o !== e.user || master_last_o !== e.last) begin
                        errors++;
                        $display("FAIL sb_payload got %h/%h/%h/%b exp %h/%h/%h/%b",
                                 master_data_o, master_strb_o, master_user_o, master_last_o,
                                 e.data, e.strb, e.user, e.last);
                    end
                end
            end
            if (slave_valid_i && slave_ready_o) begin
                sb.push_back('{slave_data_i, slave_strb_i, slave_user_i, slave_last_i});
            end
            checks++;
            if (bursts_o > count_o) begin
                errors++;
                $display("FAIL bursts_le_count got bursts=%0d exp <= count=%0d",
                         bursts_o, count_o);
            end
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        master_ready_i = 1'b0;
        drive(1'b1, 64'h0, 1'b0);
        repeat (3) tick();
        checks++;
        if (slave_ready_o !== 1'b0 || master_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got ready=%b valid=%b exp 0/0",
                     slave_ready_o, master_valid_o);
        end
        checks++;
        if (master_data_o !== 64'h0 || master_last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload got %h/%b exp 0/0", master_data_o, master_last_o);
        end
        drive(1'b0, 64'h0, 1'b0);
        rst_ni = 1'b1;
        tick();
        checks++;
        if (slave_ready_o !== 1'b1 || master_valid_o !== 1'b0 ||
            count_o !== 3'd0 || bursts_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle got ready=%b valid=%b count=%0d bursts=%0d exp 1/0/0/0",
                     slave_ready_o, master_valid_o, count_o, bursts_o);
        end
    endtask

    task automatic test_fill();
        master_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h11 * 64'(i + 1), i == 3);
            checks++;
            if (slave_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready beat %0d got %b exp 1", i, slave_ready_o);
            end
            tick();
        end
        checks++;
        if (count_o !== 3'd4 || bursts_o !== 3'd1 || slave_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got count=%0d bursts=%0d ready=%b exp 4/1/0",
                     count_o, bursts_o, slave_ready_o);
        end
        checks++;
        if (master_valid_o !== 1'b1 || master_data_o !== 64'h11) begin
            errors++;
            $display("FAIL fill_head got valid=%b data=%h exp 1/11",
                     master_valid_o, master_data_o);
        end
        drive(1'b1, 64'h55, 1'b0);
        repeat (2) tick();
        checks++;
        if (count_o !== 3'd4 || slave_ready_o !== 1'b0 || sb.size() != 4) begin
            errors++;
            $display("FAIL fill_stall got count=%0d ready=%b queued=%0d exp 4/0/4",
                     count_o, slave_ready_o, sb.size());
        end
    endtask

    task automatic test_stream();
        master_ready_i = 1'b1;
        tick();
        checks++;
        if (count_o !== 3'd3 || slave_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_first_pop got count=%0d ready=%b exp 3/1",
                     count_o, slave_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h55 + 64'h11 * 64'(k), k[0]);
            tick();
            checks++;
            if (count_o !== 3'd3) begin
                errors++;
                $display("FAIL stream_count cycle %0d got %0d exp 3", k, count_o);
            end
        end
        drive(1'b0, 64'h0, 1'b0);
        repeat (3) tick();
        checks++;
        if (count_o !== 3'd0 || bursts_o !== 3'd0 || master_valid_o !== 1'b0 ||
            sb.size() != 0) begin
            errors++;
            $display("FAIL stream_drain got count=%0d bursts=%0d valid=%b left=%0d exp 0/0/0/0",
                     count_o, bursts_o, master_valid_o, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        master_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'hA0 + 64'(i), 1'b1);
            tick();
            checks++;
            if (master_valid_o !== 1'b1 || master_data_o !== 64'hA0 + 64'(i) ||
                count_o !== 3'd1 || bursts_o !== 3'd1) begin
                errors++;
                $display("FAIL b2b_beat %0d got valid=%b data=%h count=%0d bursts=%0d exp 1/%h/1/1",
                         i, master_valid_o, master_data_o, count_o, bursts_o,
                         64'hA0 + 64'(i));
            end
        end
        drive(1'b0, 64'h0, 1'b0);
        tick();
        checks++;
        if (count_o !== 3'd0 || bursts_o !== 3'd0 || master_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got count=%0d bursts=%0d valid=%b exp 0/0/0",
                     count_o, bursts_o, master_valid_o);
        end
        master_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        int          pushed = 0;
        int          cycles = 0;
        int          pops0;
        logic        v;
        logic        acc;
        logic [63:0] nd;
        logic        nl;
        pops0 = npops;
        nd = {$urandom, $urandom};
        nl = 1'($urandom_range(0, 1));
        while ((pushed < 10 || sb.size() != 0) && cycles < 200) begin
            v = (pushed < 10) && ($urandom_range(0, 2) != 0);
            drive(v, nd, nl);
            master_ready_i = ($urandom_range(0, 2) != 0);
            acc = v && slave_ready_o;
            tick();
            if (acc) begin
                pushed++;
                nd = {$urandom, $urandom};
                nl = 1'($urandom_range(0, 1));
            end
            cycles++;
        end
        drive(1'b0, 64'h0, 1'b0);
        master_ready_i = 1'b0;
        checks++;
        if (cycles >= 200) begin
            errors++;
            $display("FAIL wrap_timeout got pushed=%0d left=%0d exp 10/0", pushed, sb.size());
        end
        checks++;
        if (npops - pops0 != 10 || count_o !== 3'd0 || bursts_o !== 3'd0) begin
            errors++;
            $display("FAIL wrap_totals got pops=%0d count=%0d bursts=%0d exp 10/0/0",
                     npops - pops0, count_o, bursts_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        master_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hD0 + 64'(i), 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        checks++;
        if (count_o !== 3'd3) begin
            errors++;
            $display("FAIL mid_held got count=%0d exp 3", count_o);
        end
        rst_ni = 1'b0;
        sb.delete();
        tick();
        checks++;
        if (count_o !== 3'd0 || bursts_o !== 3'd0 || master_valid_o !== 1'b0 ||
            slave_ready_o !== 1'b0 || master_data_o !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got count=%0d bursts=%0d valid=%b ready=%b data=%h exp 0/0/0/0/0",
                     count_o, bursts_o, master_valid_o, slave_ready_o, master_data_o);
        end
        rst_ni = 1'b1;
        drive(1'b1, 64'hBEEF, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        checks++;
        if (master_valid_o !== 1'b1 || master_data_o !== 64'hBEEF ||
            count_o !== 3'd1 || bursts_o !== 3'd1) begin
            errors++;
            $display("FAIL mid_new_first got valid=%b data=%h count=%0d bursts=%0d exp 1/beef/1/1",
                     master_valid_o, master_data_o, count_o, bursts_o);
        end
        master_ready_i = 1'b1;
        tick();
        master_ready_i = 1'b0;
        checks++;
        if (count_o !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL mid_drain got count=%0d left=%0d exp 0/0", count_o, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
